move_command_gen: RTL and testbench
===================================

# move_command_gen

Front-end input controller for the 2048 game. It turns the board's raw active-low push buttons into clean, one-hot, fixed-length command pulses on `up_state`, `down_state`, `left_state`, `right_state` and `reset_state`. These pulses drive `logic_Module` directly. The block takes `win_output` and `lose_output` back from `logic_Module` and uses them to block moves once the game is over.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable cycles needed before a debounced level changes. The default is 10 ms at 50 MHz. Must be ≥1.
- `PULSE_LEN`, default 4: number of cycles each command output stays high. Must be ≥1.

Ports:
- `clk`, in, 1: single system clock. Everything is on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `btn_n`, in, 5: raw asynchronous buttons, active-low. Bit 0 = up, 1 = down, 2 = left, 3 = right, 4 = reset.
- `win_output`, in, 1: game won, from `logic_Module`.
- `lose_output`, in, 1: game lost, from `logic_Module`.
- `up_state`, `down_state`, `left_state`, `right_state`, `reset_state`, out, 1 each: command outputs. At most one is high in any cycle.
- `busy`, out, 1: high while in PULSE or RELEASE.

## Operation

Input path:
- Each `btn_n` bit goes through a 2-flop synchronizer. Synchronizer reset value is 1 (released).
- Each synchronized bit has its own debouncer: a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - The counter counts while the synchronized value differs from the debounced value.
  - It clears to 0 on any cycle where they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced value takes the synchronized value and the counter clears.
- `pressed[i]` = NOT debounced[i].

Game-over gating:
- `game_over` = `win_output` OR `lose_output`.
- A direction press qualifies only while `game_over` = 0.
- A reset press always qualifies.

State machine (IDLE, PULSE, RELEASE):
- **IDLE**: outputs low, `busy` = 0.
  - If any qualified press exists, latch one command by fixed priority: reset > up > down > left > right.
  - Load the pulse counter with PULSE_LEN−1 and go to PULSE.
  - Unqualified presses are ignored and the state stays IDLE.
- **PULSE**: only the latched command output is high.
  - The counter decrements each cycle. At 0, go to RELEASE.
  - A change in `game_over` or in the buttons during PULSE does not shorten or alter the pulse.
- **RELEASE**: outputs low, `busy` = 1.
  - Go to IDLE only when all five debounced bits read released. Holding a button therefore gives exactly one command.

Reset values (after a clock edge with `rst_n` = 0):
- All five command outputs = 0, `busy` = 0.
- State = IDLE, all counters = 0, synchronizer and debounced bits = 1.
- A reset asserted mid-PULSE ends the pulse at that edge.

## Timing

- Count edge 1 as the first rising edge that samples a new raw level, with the raw level held stable.
- The debounced value changes at edge 2 + DEBOUNCE_CYCLES.
- The command output rises at edge 3 + DEBOUNCE_CYCLES.
- The output stays high for exactly PULSE_LEN cycles.
- `busy` rises in the same cycle as the output. After the last button is released, `busy` falls one edge after the debounced release.
- Minimum spacing between two commands = PULSE_LEN + 1 + (release debounce) + (press debounce) cycles.
- Bounces shorter than DEBOUNCE_CYCLES cycles never change the debounced level.
- If several buttons become pressed in the same cycle, only the highest-priority one is issued.
- A lower-priority button that is still held is not issued after RELEASE, because RELEASE requires all buttons released.

## Configuration

`MOVE_CMD_DEBOUNCE_EN` selects whether the debouncer is built:
- **Defined**: debouncer counters are built as described above. DEBOUNCE_CYCLES is honoured.
- **Undefined**: the counters are removed and the debounced value is the synchronized value directly. DEBOUNCE_CYCLES is ignored. Command latency becomes: output rises at edge 3.
- All other behaviour is identical either way.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4 and PULSE_LEN = 2, with the macro defined unless noted.

1. **Single press.** Hold `btn_n` = 5'b11110 (up) with `rst_n` released → `up_state` high on edges 7 and 8 only, other outputs 0, `busy` high from edge 7. After release, `busy` falls at the edge after the release debounces.
2. **Bounce and hold.** Raw up toggles every 2 cycles for 20 cycles, then is held for 40 cycles → exactly one `up_state` pulse of 2 cycles, no pulse during the toggling, no second pulse while held.
3. **Priority.** Left and right (5'b10011) go low in the same cycle → only `left_state` pulses. Then reset and down go low together (5'b01101) → only `reset_state` pulses.
4. **Game-over gating.** Set `lose_output` = 1 and press right → no output, `busy` stays 0. Press reset → `reset_state` pulses for 2 cycles. With `win_output` = 1, pressing up also gives no output.
5. **Reset mid-pulse.** Drive `rst_n` = 0 on the second cycle of a `down_state` pulse → all outputs and `busy` are 0 after that edge. After `rst_n` returns to 1 with the button still held, a new `down_state` pulse appears 7 edges later.
6. **Macro undefined.** Hold up → `up_state` high on edges 3 and 4. A single-cycle raw glitch also produces a pulse, which confirms the debouncer is removed.

Source files
------------

// File: rtl/move_command_gen.sv
// 2048 input front end: synchronises and debounces the five push buttons and emits one-hot, fixed-length command pulses.
// Define MOVE_CMD_DEBOUNCE_EN to build the per-button debounce counters; otherwise the synchronised level is used directly.
module move_command_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_LEN       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_n,
    input  logic       win_output,
    input  logic       lose_output,
    output logic       up_state,
    output logic       down_state,
    output logic       left_state,
    output logic       right_state,
    output logic       reset_state,
    output logic       busy
);

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    typedef enum logic [1:0] {IDLE, PULSE, RELEASE} state_t;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (PULSE_LEN < 1) begin : g_bad_pulse
        $error("PULSE_LEN must be at least 1");
    end

    logic [4:0]    sync1;
    logic [4:0]    sync2;
    logic [4:0]    debounced;
    logic [4:0]    pressed;
    logic [4:0]    qualified;
    logic [4:0]    select;
    logic [4:0]    cmd;
    logic          game_over;
    logic [PW-1:0] pulse_cnt;
    state_t        state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 5'h1F;
            sync2 <= 5'h1F;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

`ifdef MOVE_CMD_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] deb_cnt [5];

    // The counter only advances while the synchronised level disagrees with the accepted one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            debounced <= 5'h1F;
            for (int i = 0; i < 5; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] != debounced[i]) begin
                    if (deb_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        debounced[i] <= sync2[i];
                        deb_cnt[i]   <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + CW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign debounced = sync2;
`endif

    assign pressed   = ~debounced;
    assign game_over = win_output | lose_output;

    // Reset is always accepted so a finished game can be restarted.
    always_comb begin
        qualified = pressed & {1'b1, {4{~game_over}}};
        select    = 5'b00000;
        if (qualified[4])      select = 5'b10000;
        else if (qualified[0]) select = 5'b00001;
        else if (qualified[1]) select = 5'b00010;
        else if (qualified[2]) select = 5'b00100;
        else if (qualified[3]) select = 5'b01000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd       <= 5'b00000;
            busy      <= 1'b0;
            pulse_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|qualified) begin
                        cmd       <= select;
                        busy      <= 1'b1;
                        pulse_cnt <= PW'(PULSE_LEN - 1);
                        state     <= PULSE;
                    end
                end
                PULSE: begin
                    if (pulse_cnt == '0) begin
                        cmd   <= 5'b00000;
                        state <= RELEASE;
                    end else begin
                        pulse_cnt <= pulse_cnt - PW'(1);
                    end
                end
                RELEASE: begin
                    // Waiting for every button makes a held button yield only one command.
                    if (&debounced) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    cmd   <= 5'b00000;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign up_state    = cmd[0];
    assign down_state  = cmd[1];
    assign left_state  = cmd[2];
    assign right_state = cmd[3];
    assign reset_state = cmd[4];

endmodule

// File: tb/tb_move_command_gen.sv
// Directed self-checking bench for move_command_gen with DEBOUNCE_CYCLES=4, PULSE_LEN=2.
// Expected latencies follow MOVE_CMD_DEBOUNCE_EN, matching whichever build of the design is compiled.
module tb_move_command_gen;

`ifdef MOVE_CMD_DEBOUNCE_EN
    localparam int DEB_EDGE = 6;
`else
    localparam int DEB_EDGE = 2;
`endif

    logic       clk;
    logic       rst_n;
    logic [4:0] btn_n;
    logic       win_output;
    logic       lose_output;
    logic       up_state;
    logic       down_state;
    logic       left_state;
    logic       right_state;
    logic       reset_state;
    logic       busy;
    logic [4:0] cmd;

    int tests_run;
    int tests_failed;

    move_command_gen #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_LEN      (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_n      (btn_n),
        .win_output (win_output),
        .lose_output(lose_output),
        .up_state   (up_state),
        .down_state (down_state),
        .left_state (left_state),
        .right_state(right_state),
        .reset_state(reset_state),
        .busy       (busy)
    );

    assign cmd = {reset_state, right_state, left_state, down_state, up_state};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] b, input int n);
        btn_n = b;
        repeat (n) step();
    endtask

    // Caller has just changed the raw buttons; the next edge is edge 1.
    task automatic expectPulse(input string tag, input logic [4:0] expected);
        repeat (DEB_EDGE) step();
        checkOutput({tag, "_before"}, {3'b000, busy, cmd}, 8'h00);
        step();
        checkOutput({tag, "_first"}, {3'b000, busy, cmd}, {3'b001, expected});
        step();
        checkOutput({tag, "_second"}, {3'b000, busy, cmd}, {3'b001, expected});
        step();
        checkOutput({tag, "_after"}, {3'b000, busy, cmd}, 8'h20);
    endtask

    task automatic releaseAll(input string tag);
        btn_n = 5'h1F;
        repeat (DEB_EDGE) step();
        checkOutput({tag, "_busy_hold"}, {7'd0, busy}, 8'h01);
        step();
        checkOutput({tag, "_busy_fall"}, {7'd0, busy}, 8'h00);
    endtask

    initial begin
        int highs;
        int rises;
        int rise_edge;
        logic prev_up;

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        btn_n        = 5'h1F;
        win_output   = 1'b0;
        lose_output  = 1'b0;
        repeat (2) step();
        checkOutput("reset_state", {3'b000, busy, cmd}, 8'h00);
        rst_n = 1'b1;

        btn_n = 5'b11110;
        expectPulse("single_up", 5'b00001);
        releaseAll("single_up_rel");

`ifdef MOVE_CMD_DEBOUNCE_EN
        for (int i = 0; i < 20; i++) begin
            btn_n = ((i % 4) < 2) ? 5'b11110 : 5'b11111;
            step();
            checkOutput("bounce_quiet", {3'b000, busy, cmd}, 8'h00);
        end
        btn_n     = 5'b11110;
        highs     = 0;
        rises     = 0;
        rise_edge = 0;
        prev_up   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (up_state) highs++;
            if (up_state && !prev_up) begin
                rises++;
                if (rise_edge == 0) rise_edge = i + 1;
            end
            prev_up = up_state;
        end
        checkOutput("hold_high_cycles", 8'(highs), 8'd2);
        checkOutput("hold_rise_count", 8'(rises), 8'd1);
        checkOutput("hold_rise_edge", 8'(rise_edge), 8'd7);
        releaseAll("hold_rel");
`endif

        btn_n = 5'b10011;
        expectPulse("prio_left", 5'b00100);
        releaseAll("prio_left_rel");
        btn_n = 5'b01101;
        expectPulse("prio_reset", 5'b10000);
        releaseAll("prio_reset_rel");

        lose_output = 1'b1;
        applyStimulus(5'b10111, DEB_EDGE + 3);
        checkOutput("gate_lose_right", {3'b000, busy, cmd}, 8'h00);
        applyStimulus(5'b11111, DEB_EDGE + 2);
        btn_n = 5'b01111;
        expectPulse("gate_reset", 5'b10000);
        releaseAll("gate_reset_rel");
        lose_output = 1'b0;
        win_output  = 1'b1;
        applyStimulus(5'b11110, DEB_EDGE + 3);
        checkOutput("gate_win_up", {3'b000, busy, cmd}, 8'h00);
        applyStimulus(5'b11111, DEB_EDGE + 2);
        win_output = 1'b0;

        applyStimulus(5'b11101, DEB_EDGE + 1);
        checkOutput("midpulse_first", {3'b000, busy, cmd}, 8'h22);
        rst_n = 1'b0;
        step();
        checkOutput("midpulse_reset", {3'b000, busy, cmd}, 8'h00);
        rst_n = 1'b1;
        expectPulse("midpulse_repress", 5'b00010);
        releaseAll("midpulse_rel");

`ifndef MOVE_CMD_DEBOUNCE_EN
        applyStimulus(5'b11110, 1);
        applyStimulus(5'b11111, 2);
        checkOutput("glitch_first", {3'b000, busy, cmd}, 8'h21);
        step();
        checkOutput("glitch_second", {3'b000, busy, cmd}, 8'h21);
        step();
        checkOutput("glitch_release", {3'b000, busy, cmd}, 8'h20);
        step();
        checkOutput("glitch_idle", {3'b000, busy, cmd}, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
